// File: rtl/psram_pkg.sv
// Shared definitions for psram_clk-domain blocks: read-phase FSM encoding,
// nibble/word geometry and the nibble-to-bit placement used by word packers.
package psram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DUMMY = 2'd1,
      ST_DATA  = 2'd2,
      ST_DRAIN = 2'd3
   } rd_state_e;

   localparam int NIB_PER_WORD = 8;

   // Little-endian bytes, high nibble first: k=0 -> [7:4], k=1 -> [3:0], k=2 -> [15:12] ...
   function automatic logic [4:0] nib_pos(input logic [2:0] k);
      return {k[2:1], ~k[0], 2'b00};
   endfunction

endpackage

// File: rtl/psram_sync_fifo.sv
// Single-clock FIFO for psram_clk-domain blocks. Head word is presented directly
// from the storage registers; head reads as zero while the FIFO is empty.
module psram_sync_fifo #(
   parameter int  DEPTH = 4,
   parameter int  WIDTH = 32,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             psram_clk,
   input  logic             psram_rstn,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
   assign do_push = push & (~full | do_pop);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge psram_clk or negedge psram_rstn) begin
      if (!psram_rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // NOTE: storage has no reset; pointers and count define validity, and head is masked when empty.
   always_ff @(posedge psram_clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/psram_rd_deser.sv
// Read-data front end: drives the read-phase SCLK enable, discards dummy nibbles,
// packs sampled DQ nibbles into 32-bit words and flow-controls SCLK by FIFO credit.
module psram_rd_deser
   import psram_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int SAMPLE_LAT = 2,
   parameter int LEN_W      = 8
) (
   input  logic             psram_clk,
   input  logic             psram_rstn,
   input  logic             psram_start,
   input  logic             rd_start,
   input  logic [LEN_W-1:0] rd_len,
   input  logic [4:0]       dummy_cyc,
   output logic             sck_en,
   input  logic [3:0]       dq_in,
   output logic             rx_vld,
   output logic [31:0]      rx_data,
   input  logic             rx_rdy,
   output logic             rd_busy,
   output logic             rd_done,
   output logic             ovf_err
);

   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int NW    = LEN_W + 3;
   localparam int OCC_W = $clog2(DEPTH * NIB_PER_WORD + NIB_PER_WORD + SAMPLE_LAT + 1) + 1;
   localparam logic [OCC_W-1:0] CAP_NIB = OCC_W'(DEPTH * NIB_PER_WORD);

   rd_state_e           state;
   rd_state_e           state_nxt;
   logic [LEN_W-1:0]    len_q;
   logic [4:0]          dummy_cnt;
   logic [NW-1:0]       issued;
   logic [NW-1:0]       target;
   logic                is_data;

   logic [SAMPLE_LAT-1:0] dl_vld;
   logic [SAMPLE_LAT-1:0] dl_dat;

   logic [31:0]         pk_data;
   logic [31:0]         pk_word;
   logic [2:0]          pk_cnt;
   logic                capture;

   logic                fifo_push;
   logic                fifo_pop;
   logic [CW-1:0]       fifo_count;
   logic                fifo_empty;
   logic                fifo_full;

   logic [OCC_W-1:0]    inflight;
   logic [OCC_W-1:0]    occ_net;
   logic [OCC_W-1:0]    credit;
   logic                ovf_q;

   assign target  = {len_q, 3'b000};
   assign rx_vld  = ~fifo_empty;
   assign rd_busy = (state != ST_IDLE);
   assign ovf_err = ovf_q;

   // ---------------- packer ----------------
   assign capture   = dl_vld[SAMPLE_LAT-1] & dl_dat[SAMPLE_LAT-1];
   assign fifo_push = capture & (pk_cnt == 3'd7);
   assign fifo_pop  = rx_vld & rx_rdy;

   always_comb begin
      pk_word = pk_data;
      pk_word[nib_pos(pk_cnt) +: 4] = dq_in;
   end

   // ---------------- credit ----------------
   always_comb begin
      inflight = '0;
      for (int i = 0; i < SAMPLE_LAT; i++) begin
         inflight = inflight + OCC_W'(dl_vld[i] & dl_dat[i]);
      end
   end

   // Occupancy after this cycle's pop; nibbles never leave the pipeline except by a pop.
   assign occ_net = (OCC_W'(fifo_count) << 3) + OCC_W'(pk_cnt) + inflight
                    - (fifo_pop ? OCC_W'(NIB_PER_WORD) : '0);
   assign credit  = CAP_NIB - occ_net;

   // ---------------- FSM ----------------
   always_ff @(posedge psram_clk or negedge psram_rstn) begin
      if (!psram_rstn) state <= ST_IDLE;
      else             state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      sck_en    = 1'b0;
      is_data   = 1'b0;
      rd_done   = 1'b0;
      if (psram_start) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (rd_start) begin
                  if (dummy_cyc != 5'd0)    state_nxt = ST_DUMMY;
                  else if (rd_len != '0)    state_nxt = ST_DATA;
                  else                      state_nxt = ST_DRAIN;
               end
            end
            ST_DUMMY: begin
               sck_en = 1'b1;
               if (dummy_cnt == 5'd1) state_nxt = (len_q != '0) ? ST_DATA : ST_DRAIN;
            end
            ST_DATA: begin
               is_data = 1'b1;
               sck_en  = (issued < target) && (credit != '0);
               if ((issued >= target) || (sck_en && (issued == target - NW'(1))))
                  state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
               if ((dl_vld == '0) && (pk_cnt == 3'd0) && fifo_empty) begin
                  rd_done   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // ---------------- burst counters ----------------
   always_ff @(posedge psram_clk or negedge psram_rstn) begin
      if (!psram_rstn) begin
         len_q     <= '0;
         dummy_cnt <= '0;
         issued    <= '0;
         ovf_q     <= 1'b0;
      end else if (psram_start) begin
         len_q     <= '0;
         dummy_cnt <= '0;
         issued    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && rd_start) begin
            len_q     <= rd_len;
            dummy_cnt <= dummy_cyc;
            issued    <= '0;
         end
         if (state == ST_DUMMY) dummy_cnt <= dummy_cnt - 5'd1;
         if (sck_en && is_data) issued <= issued + NW'(1);
         if (fifo_push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
      end
   end

   // ---------------- delay line and packer registers ----------------
   always_ff @(posedge psram_clk or negedge psram_rstn) begin
      if (!psram_rstn) begin
         dl_vld  <= '0;
         dl_dat  <= '0;
         pk_data <= '0;
         pk_cnt  <= '0;
      end else if (psram_start) begin
         dl_vld  <= '0;
         dl_dat  <= '0;
         pk_data <= '0;
         pk_cnt  <= '0;
      end else begin
         dl_vld[0] <= sck_en;
         dl_dat[0] <= is_data;
         for (int i = 1; i < SAMPLE_LAT; i++) begin
            dl_vld[i] <= dl_vld[i-1];
            dl_dat[i] <= dl_dat[i-1];
         end
         if (capture) begin
            pk_cnt  <= pk_cnt + 3'd1;
            pk_data <= fifo_push ? '0 : pk_word;
         end
      end
   end

   psram_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .psram_clk  (psram_clk),
      .psram_rstn (psram_rstn),
      .clr        (psram_start),
      .push       (fifo_push),
      .push_data  (pk_word),
      .pop        (fifo_pop),
      .head       (rx_data),
      .count      (fifo_count),
      .empty      (fifo_empty),
      .full       (fifo_full)
   );

endmodule
